// File: rtl/error_report_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// error_report_arbiter_pkg
// Shared definitions for the error report arbiter: FSM state encoding, table
// geometry, flush timeout and the bit layout of a 23-bit error table entry:
//   [22:7] image index | [6] camera id | [5:3] camera flags | [2:0] memory flags
// -----------------------------------------------------------------------------
package error_report_arbiter_pkg;

  localparam int ENTRY_W       = 23;
  localparam int TABLE_DEPTH   = 8;
  localparam int FLUSH_TIMEOUT = 16;

  localparam int INDEX_W = 16;
  localparam int FLAG_W  = 3;
  localparam int COUNT_W = $clog2(TABLE_DEPTH + 1);  // must hold 0..TABLE_DEPTH
  localparam int TIMER_W = $clog2(FLUSH_TIMEOUT);

  // Field positions inside an entry
  localparam int MEM_FLAGS_LSB = 0;
  localparam int CAM_FLAGS_LSB = 3;
  localparam int CAMID_BIT     = 6;
  localparam int INDEX_LSB     = 7;

  // Requester slots, shared by the request/grant vectors and the RR pointer
  localparam int REQ_CAM = 0;
  localparam int REQ_MEM = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [INDEX_W-1:0] index,
    input logic               camid,
    input logic [FLAG_W-1:0]  cam_flags,
    input logic [FLAG_W-1:0]  mem_flags
  );
    logic [ENTRY_W-1:0] e;
    e                             = '0;
    e[INDEX_LSB +: INDEX_W]       = index;
    e[CAMID_BIT]                  = camid;
    e[CAM_FLAGS_LSB +: FLAG_W]    = cam_flags;
    e[MEM_FLAGS_LSB +: FLAG_W]    = mem_flags;
    return e;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. A lone request is granted whatever the pointer
// says; on a tie the pointer picks the winner. Each accepted grant (advance_i)
// moves the pointer to the requester that did not win.
// Ports:
//   sysClk, reset  clock / asynchronous active-high reset (pointer -> camera)
//   req_i[1:0]     requests, index REQ_CAM / REQ_MEM
//   advance_i      the current grant is being taken this cycle
//   grant_o[1:0]   one-hot (or zero) combinational grant
// -----------------------------------------------------------------------------
module rr_arbiter2
  import error_report_arbiter_pkg::*;
(
  input  logic       sysClk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;  // slot that wins a tie
  logic ptr_d;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_o = req_i;
    if (&req_i) begin
      grant_o        = '0;
      grant_o[ptr_q] = 1'b1;
    end
    ptr_d = ptr_q;
    if (advance_i) begin
      // Camera won -> memory next; memory won -> camera next.
      ptr_d = grant_o[REQ_CAM];
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'(REQ_CAM);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/error_report_arbiter.sv
// -----------------------------------------------------------------------------
// error_report_arbiter
// Arbitrates camera and flash error reports into an 8-entry error table and
// runs table flushes that forward returned entries to a report port.
// Ports:
//   sysClk, reset                 clock / asynchronous active-high reset
//   cam_err_*                     camera request (held until ack), index, id,
//                                 flags {timeout, cap_fail, not_detected}
//   mem_err_*                     flash request (held until ack), index,
//                                 flags {write_fail, read_fail, erase_fail}
//   flush_req                     one-cycle flush pulse
//   flush_busy/done/timeout       flush status (timeout sticky to next flush)
//   tbl_entry/valid/flush         error table write port and flush command
//   tbl_rd_data/valid             entries streamed back during a flush
//   rpt_data/valid                forwarded entries, no backpressure
//   entry_count, overflow         entries logged since last flush, sticky full
// -----------------------------------------------------------------------------
module error_report_arbiter
  import error_report_arbiter_pkg::*;
(
  input  logic               sysClk,
  input  logic               reset,
  input  logic               cam_err_req,
  input  logic [INDEX_W-1:0] cam_err_index,
  input  logic               cam_err_camid,
  input  logic [FLAG_W-1:0]  cam_err_flags,
  output logic               cam_err_ack,
  input  logic               mem_err_req,
  input  logic [INDEX_W-1:0] mem_err_index,
  input  logic [FLAG_W-1:0]  mem_err_flags,
  output logic               mem_err_ack,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               flush_timeout,
  output logic [ENTRY_W-1:0] tbl_entry,
  output logic               tbl_valid,
  output logic               tbl_flush,
  input  logic [ENTRY_W-1:0] tbl_rd_data,
  input  logic               tbl_rd_valid,
  output logic [ENTRY_W-1:0] rpt_data,
  output logic               rpt_valid,
  output logic [COUNT_W-1:0] entry_count,
  output logic               overflow
);

  state_e               state_q;
  logic                 flush_pend_q;
  logic                 rd_seen_q;      // at least one entry returned this flush
  logic [TIMER_W-1:0]   timer_q;        // silent FLUSH cycles so far
  logic                 cam_ack_q, mem_ack_q;
  logic                 flush_busy_q, flush_done_q, flush_timeout_q;
  logic [ENTRY_W-1:0]   tbl_entry_q;
  logic                 tbl_valid_q, tbl_flush_q;
  logic [ENTRY_W-1:0]   rpt_data_q;
  logic                 rpt_valid_q;
  logic [COUNT_W-1:0]   entry_count_q;
  logic                 overflow_q;

  logic [1:0]           grant;
  logic                 advance;
  logic [ENTRY_W-1:0]   entry_d;
  logic                 has_flags_d;
  logic                 room_d;

  rr_arbiter2 u_rr (
    .sysClk    (sysClk),
    .reset     (reset),
    .req_i     ({mem_err_req, cam_err_req}),
    .advance_i (advance),
    .grant_o   (grant)
  );

  // A pending flush outranks requests, so the pointer only moves on a real grant.
  assign advance = (state_q == IDLE) && !flush_pend_q && (|grant);

  always_comb begin
    if (grant[REQ_MEM]) begin
      entry_d     = pack_entry(mem_err_index, 1'b0, '0, mem_err_flags);
      has_flags_d = |mem_err_flags;
    end else begin
      entry_d     = pack_entry(cam_err_index, cam_err_camid, cam_err_flags, '0);
      has_flags_d = |cam_err_flags;
    end
    room_d = entry_count_q < COUNT_W'(TABLE_DEPTH);
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      flush_pend_q    <= 1'b0;
      rd_seen_q       <= 1'b0;
      timer_q         <= '0;
      cam_ack_q       <= 1'b0;
      mem_ack_q       <= 1'b0;
      flush_busy_q    <= 1'b0;
      flush_done_q    <= 1'b0;
      flush_timeout_q <= 1'b0;
      tbl_entry_q     <= '0;
      tbl_valid_q     <= 1'b0;
      tbl_flush_q     <= 1'b0;
      rpt_data_q      <= '0;
      rpt_valid_q     <= 1'b0;
      entry_count_q   <= '0;
      overflow_q      <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      cam_ack_q    <= 1'b0;
      mem_ack_q    <= 1'b0;
      tbl_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      rpt_valid_q  <= 1'b0;

      if (flush_req && !flush_busy_q) begin
        flush_pend_q    <= 1'b1;
        flush_timeout_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (flush_pend_q) begin
            state_q      <= FLUSH;
            flush_pend_q <= 1'b0;
            tbl_flush_q  <= 1'b1;
            flush_busy_q <= 1'b1;
            timer_q      <= '0;
            rd_seen_q    <= 1'b0;
          end else if (advance) begin
            state_q     <= WRITE;
            cam_ack_q   <= grant[REQ_CAM];
            mem_ack_q   <= grant[REQ_MEM];
            tbl_entry_q <= entry_d;
            // Flag-less reports are acknowledged but never logged.
            if (has_flags_d) begin
              if (room_d) begin
                tbl_valid_q   <= 1'b1;
                entry_count_q <= entry_count_q + 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
            end
          end
        end

        WRITE: state_q <= IDLE;

        FLUSH: begin
          rpt_valid_q <= tbl_rd_valid;
          if (tbl_rd_valid) begin
            rpt_data_q <= tbl_rd_data;
            rd_seen_q  <= 1'b1;
          end else if (rd_seen_q || (timer_q == TIMER_W'(FLUSH_TIMEOUT - 1))) begin
            // End of the returned burst, or the table never answered.
            state_q         <= DONE;
            tbl_flush_q     <= 1'b0;
            flush_busy_q    <= 1'b0;
            flush_done_q    <= 1'b1;
            flush_timeout_q <= !rd_seen_q;
            entry_count_q   <= '0;
            overflow_q      <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        DONE: state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cam_err_ack   = cam_ack_q;
  assign mem_err_ack   = mem_ack_q;
  assign flush_busy    = flush_busy_q;
  assign flush_done    = flush_done_q;
  assign flush_timeout = flush_timeout_q;
  assign tbl_entry     = tbl_entry_q;
  assign tbl_valid     = tbl_valid_q;
  assign tbl_flush     = tbl_flush_q;
  assign rpt_data      = rpt_data_q;
  assign rpt_valid     = rpt_valid_q;
  assign entry_count   = entry_count_q;
  assign overflow      = overflow_q;

endmodule
